// File: rtl/audio_pkg.sv
// audio_pkg: shared types and sample-to-duty conversion for the PWM audio path.
package audio_pkg;
  localparam int SAMPLE_W = 16;
  typedef enum logic [1:0] {IDLE, PRIMING, PLAYING} play_state_t;
  typedef logic signed [SAMPLE_W-1:0] sample_t;
  function automatic logic [SAMPLE_W-1:0] to_offset_duty(sample_t s);
    return {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
  endfunction
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous sample FIFO; a full FIFO accepts a push only alongside a pop.
module sample_fifo
  import audio_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        flush,
  input  logic        push,
  input  logic        pop,
  input  sample_t     din,
  output sample_t     dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] level
);
  sample_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = level == '0;
  assign full = level == (AW+1)'(DEPTH);
  assign dout = mem[rd_ptr];
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  always_ff @(posedge clk_in)
    if (do_push && !flush) mem[wr_ptr] <= din;
  always_ff @(posedge clk_in or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/audio_pwm_out.sv
// audio_pwm_out: buffers received audio samples and plays them at a fixed rate
// as single-bit PWM, reporting overflow pulses and a saturating underrun count.
module audio_pwm_out
  import audio_pkg::*;
#(
  parameter int CLK_HZ = 25_000_000,
  parameter int SAMPLE_DIV = 520,
  parameter int PWM_BITS = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PRIME_LEVEL = 8
) (
  input  logic                         clk_in,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [15:0]                  sample_in,
  input  logic                         sample_valid,
  output logic                         pwm_out,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         playing,
  output logic                         overflow,
  output logic [7:0]                   underrun_count
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int DW = $clog2(SAMPLE_DIV);
  localparam logic [PWM_BITS-1:0] MIDSCALE = {1'b1, {(PWM_BITS-1){1'b0}}};
  if (SAMPLE_DIV < 2 || SAMPLE_DIV > CLK_HZ || PRIME_LEVEL < 1 || PRIME_LEVEL > FIFO_DEPTH)
    begin : g_bad_params
      $error("audio_pwm_out: invalid parameters");
    end
  play_state_t state;
  sample_t cur_sample, head;
  logic [DW-1:0] div;
  logic [PWM_BITS-1:0] pwm_cnt, duty;
  logic tick, push, pop, full, empty;
  assign tick = enable && div == DW'(SAMPLE_DIV - 1);
  assign push = sample_valid && enable;
  assign pop = state == PLAYING && tick && !empty;
  assign playing = state == PLAYING;
  sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_in(clk_in),
    .reset(reset),
    .flush(!enable),
    .push(push),
    .pop(pop),
    .din(sample_in),
    .dout(head),
    .full(full),
    .empty(empty),
    .level(fifo_level)
  );
  always_ff @(posedge clk_in or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cur_sample <= '0;
      div <= '0;
      pwm_cnt <= '0;
      duty <= MIDSCALE;
      pwm_out <= 1'b0;
      overflow <= 1'b0;
      underrun_count <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      // duty only changes at the period boundary so no partial pulse is emitted
      if (&pwm_cnt) duty <= PWM_BITS'(to_offset_duty(cur_sample) >> (SAMPLE_W - PWM_BITS));
      pwm_out <= pwm_cnt < duty;
      overflow <= push && full && !pop;
      div <= (!enable || tick) ? '0 : div + 1'b1;
      if (!enable) begin
        state <= IDLE;
        cur_sample <= '0;
      end else
        case (state)
          IDLE: state <= PRIMING;
          PRIMING: if (fifo_level >= LW'(PRIME_LEVEL)) state <= PLAYING;
          default:
            if (tick) begin
              if (!empty) cur_sample <= head;
              else begin
                cur_sample <= '0;
                state <= PRIMING;
                if (underrun_count != 8'hFF) underrun_count <= underrun_count + 1'b1;
              end
            end
        endcase
    end
endmodule

// File: tb/tb_audio_pwm_out.sv
// tb_audio_pwm_out: directed bench for audio_pwm_out covering priming, playback,
// underrun, overflow, full-FIFO push with pop, enable drop and async reset.
module tb_audio_pwm_out;
  logic clk_in = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic sample_valid = 1'b0;
  logic [15:0] sample_in = '0;
  logic pwm_out, playing, overflow;
  logic [4:0] fifo_level;
  logic [7:0] underrun_count;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int e1, n, ov;

  audio_pwm_out dut (
    .clk_in(clk_in),
    .reset(reset),
    .enable(enable),
    .sample_in(sample_in),
    .sample_valid(sample_valid),
    .pwm_out(pwm_out),
    .fifo_level(fifo_level),
    .playing(playing),
    .overflow(overflow),
    .underrun_count(underrun_count)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic count_high(output int cnt);
    cnt = 0;
    repeat (256) begin
      step();
      cnt += int'(pwm_out);
    end
  endtask

  task automatic measure(input string tag, input int exp);
    int c;
    repeat (260) step();
    count_high(c);
    check(tag, c, exp);
  endtask

  task automatic wait_level(input string tag, input int lv, input int bound);
    for (int i = 0; i < bound && fifo_level !== 5'(lv); i++) step();
    check(tag, fifo_level, lv);
  endtask

  task automatic fill8(input logic [15:0] v);
    for (int k = 0; k < 8; k++) begin
      sample_in = v;
      sample_valid = 1'b1;
      step();
      sample_valid = 1'b0;
      if (k < 7) repeat (9) step();
    end
  endtask

  initial begin
    #3;
    check("rst_pwm", pwm_out, 0);
    check("rst_level", fifo_level, 0);
    check("rst_playing", playing, 0);
    check("rst_overflow", overflow, 0);
    check("rst_underrun", underrun_count, 0);
    step();
    reset = 1'b1;
    step();
    // prime with full-scale positive samples
    enable = 1'b1;
    fill8(16'h7FFF);
    check("prime_level", fifo_level, 8);
    check("prime_not_playing", playing, 0);
    step();
    check("prime_playing", playing, 1);
    wait_level("first_pop", 7, 600);
    measure("duty_7fff", 255);
    // drain to underrun
    for (int i = 0; i < 4700 && playing === 1'b1; i++) step();
    check("underrun_playing", playing, 0);
    check("underrun_count1", underrun_count, 1);
    check("underrun_level", fifo_level, 0);
    measure("duty_underrun", 128);
    // refill with full-scale negative samples
    fill8(16'h8000);
    check("refill_level", fifo_level, 8);
    step();
    check("refill_playing", playing, 1);
    wait_level("refill_pop", 7, 600);
    measure("duty_8000", 0);
    // drop enable with 5 queued
    wait_level("five_queued", 5, 1200);
    enable = 1'b0;
    step();
    check("drop_playing", playing, 0);
    check("drop_level", fifo_level, 0);
    check("drop_underrun", underrun_count, 1);
    measure("duty_idle", 128);
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    check("idle_push_ovf", overflow, 0);
    check("idle_push_level", fifo_level, 0);
    // 17 back-to-back pushes, oldest is 0x4000
    e1 = cyc;
    ov = 0;
    enable = 1'b1;
    sample_valid = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      sample_in = (i == 1) ? 16'h4000 : 16'hC000;
      step();
      ov += int'(overflow);
      if (i == 16) begin
        check("fill16_level", fifo_level, 16);
        check("fill16_ovf", overflow, 0);
      end
    end
    check("push17_ovf", overflow, 1);
    check("push17_level", fifo_level, 16);
    sample_valid = 1'b0;
    step();
    ov += int'(overflow);
    check("ovf_cleared", overflow, 0);
    check("ovf_pulses", ov, 1);
    // push coincides with the first tick: pop makes room
    while (cyc < e1 + 519) step();
    sample_in = 16'h1234;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    check("full_tick_ovf", overflow, 0);
    check("full_tick_level", fifo_level, 16);
    measure("duty_oldest", 192);
    // async reset while pwm_out is high
    for (int i = 0; i < 256 && pwm_out !== 1'b1; i++) step();
    check("pwm_high_seen", pwm_out, 1);
    #2;
    reset = 1'b0;
    #1;
    check("async_pwm", pwm_out, 0);
    check("async_level", fifo_level, 0);
    check("async_playing", playing, 0);
    check("async_underrun", underrun_count, 0);
    check("async_overflow", overflow, 0);
    enable = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    check("fresh_level", fifo_level, 0);
    check("fresh_playing", playing, 0);
    measure("fresh_duty", 128);
    enable = 1'b1;
    sample_in = 16'h7FFF;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    check("fresh_push_level", fifo_level, 1);
    step();
    check("fresh_priming", playing, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
